red_send: RTL and testbench

- NEC-format infrared transmitter; the transmit-side counterpart of the IR receiver in the voice design.
- Accepts a 32-bit code word plus a start strobe.
- Emits the modulated IR LED drive: 9 ms leader, 32 pulse-distance bits sent LSB first, stop mark, then a mandatory inter-frame gap.
- Also supports the NEC repeat frame. Runs on the 1 µs tick clock produced by the top-level clock divider.

---
 rtl/red_pkg.sv | 29 ++
 rtl/red_send_if.sv | 13 +
 rtl/red_carrier.sv | 34 +++
 rtl/red_send.sv | 122 ++++++++++++
 tb/tb_red_send.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/red_pkg.sv
// Shared NEC IR definitions: FSM state encoding and default timing in 1 us ticks.
// The receiver uses the same timing constants as its decode thresholds.
package red_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LMARK,
    S_LSPACE,
    S_BMARK,
    S_BSPACE,
    S_SMARK,
    S_GAP
  } red_state_t;

  localparam int NEC_CARRIER_HALF = 13;
  localparam int NEC_LEAD_MARK    = 9000;
  localparam int NEC_LEAD_SPACE   = 4500;
  localparam int NEC_RPT_SPACE    = 2250;
  localparam int NEC_BIT_MARK     = 560;
  localparam int NEC_ZERO_SPACE   = 560;
  localparam int NEC_ONE_SPACE    = 1690;
  localparam int NEC_GAP          = 40000;

  // Down-counter reload value: a state loaded with dur(n) lasts exactly n cycles.
  function automatic logic [15:0] dur(input int len);
    return 16'(len - 1);
  endfunction

endpackage

// File: rtl/red_send_if.sv
// Code word / strobe inputs and LED drive / status outputs of the NEC transmitter.
// Strobes are level-sampled only while the transmitter is idle; no backpressure.
interface red_send_if;
  logic [31:0] i_data;
  logic        i_st;
  logic        i_repeat;
  logic        o_red;
  logic        o_busy;
  logic        o_done;

  modport master (output i_data, i_st, i_repeat, input o_red, o_busy, o_done);
  modport slave  (input i_data, i_st, i_repeat, output o_red, o_busy, o_done);
endinterface

// File: rtl/red_carrier.sv
// Mark modulator: registered carrier, high for HALF cycles right after restart, then toggling.
// Output is forced low whenever enable is low; EN=0 gives a steady high mark.
module red_carrier #(
  parameter int HALF = 13,
  parameter bit EN   = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  input  logic restart,
  output logic carrier
);

  logic [15:0] phase;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase   <= '0;
      carrier <= 1'b0;
    end else if (!enable) begin
      phase   <= '0;
      carrier <= 1'b0;
    end else if (restart || !EN) begin
      phase   <= 16'(HALF - 1);
      carrier <= 1'b1;
    end else if (phase == 16'd0) begin
      phase   <= 16'(HALF - 1);
      carrier <= ~carrier;
    end else begin
      phase <= phase - 16'd1;
    end
  end

endmodule

// File: rtl/red_send.sv
// NEC IR transmitter: leader, 32 LSB-first pulse-distance bits, stop mark, then idle gap.
// First mark cycle appears on the edge that samples the strobe; strobes are ignored while busy.
module red_send
  import red_pkg::*;
#(
  parameter int CARRIER_HALF = NEC_CARRIER_HALF,
  parameter bit CARRIER_EN   = 1'b1,
  parameter int LEAD_MARK    = NEC_LEAD_MARK,
  parameter int LEAD_SPACE   = NEC_LEAD_SPACE,
  parameter int RPT_SPACE    = NEC_RPT_SPACE,
  parameter int BIT_MARK     = NEC_BIT_MARK,
  parameter int ZERO_SPACE   = NEC_ZERO_SPACE,
  parameter int ONE_SPACE    = NEC_ONE_SPACE,
  parameter int GAP          = NEC_GAP
) (
  input logic       i_clk_1us,
  input logic       i_rst_n,
  red_send_if.slave bus
);

  red_state_t  state;
  logic [15:0] cnt;
  logic [31:0] shift;
  logic [4:0]  bit_cnt;
  logic        rpt;
  logic        busy;
  logic        done;
  logic        red;
  logic        cnt_zero;
  logic        mark_start;
  logic        mark_hold;

  assign cnt_zero   = (cnt == 16'd0);
  assign bus.o_red  = red;
  assign bus.o_busy = busy;
  assign bus.o_done = done;

  // Carrier control looks one edge ahead so the carrier flop itself is the registered LED drive.
  always_comb begin
    mark_start = 1'b0;
    mark_hold  = 1'b0;
    unique case (state)
      S_IDLE:                     mark_start = bus.i_st | bus.i_repeat;
      S_LSPACE, S_BSPACE:         mark_start = cnt_zero;
      S_LMARK, S_BMARK, S_SMARK:  mark_hold  = !cnt_zero;
      default:                    ;
    endcase
  end

  red_carrier #(
    .HALF (CARRIER_HALF),
    .EN   (CARRIER_EN)
  ) u_carrier (
    .clk     (i_clk_1us),
    .rst_n   (i_rst_n),
    .enable  (mark_start | mark_hold),
    .restart (mark_start),
    .carrier (red)
  );

  always_ff @(posedge i_clk_1us or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state   <= S_IDLE;
      cnt     <= '0;
      shift   <= '0;
      bit_cnt <= '0;
      rpt     <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (!cnt_zero) cnt <= cnt - 16'd1;
      unique case (state)
        S_IDLE: begin
          if (bus.i_st) begin
            shift   <= bus.i_data;
            rpt     <= 1'b0;
            bit_cnt <= '0;
            busy    <= 1'b1;
            cnt     <= dur(LEAD_MARK);
            state   <= S_LMARK;
          end else if (bus.i_repeat) begin
            rpt     <= 1'b1;
            bit_cnt <= '0;
            busy    <= 1'b1;
            cnt     <= dur(LEAD_MARK);
            state   <= S_LMARK;
          end
        end
        S_LMARK: if (cnt_zero) begin
          cnt   <= rpt ? dur(RPT_SPACE) : dur(LEAD_SPACE);
          state <= S_LSPACE;
        end
        S_LSPACE: if (cnt_zero) begin
          cnt   <= dur(BIT_MARK);
          state <= rpt ? S_SMARK : S_BMARK;
        end
        S_BMARK: if (cnt_zero) begin
          cnt   <= shift[0] ? dur(ONE_SPACE) : dur(ZERO_SPACE);
          state <= S_BSPACE;
        end
        S_BSPACE: if (cnt_zero) begin
          shift   <= {1'b0, shift[31:1]};
          bit_cnt <= bit_cnt + 5'd1;
          cnt     <= dur(BIT_MARK);
          state   <= (bit_cnt == 5'd31) ? S_SMARK : S_BMARK;
        end
        S_SMARK: if (cnt_zero) begin
          done  <= 1'b1;
          cnt   <= dur(GAP);
          state <= S_GAP;
        end
        S_GAP: if (cnt_zero) begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_red_send.sv
// Bench for red_send with shortened NEC timing; checks every cycle of each frame against
// a waveform built from the frame rules and decodes the LED envelope back to the code word.
module tb_red_send;

  localparam int CH = 3;
  localparam int LM = 180;
  localparam int LS = 90;
  localparam int RS = 45;
  localparam int BM = 11;
  localparam int ZS = 11;
  localparam int OS = 34;
  localparam int GP = 800;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  red_send_if bus ();

  always #5 clk = ~clk;

  red_send #(
    .CARRIER_HALF (CH),
    .CARRIER_EN   (1'b1),
    .LEAD_MARK    (LM),
    .LEAD_SPACE   (LS),
    .RPT_SPACE    (RS),
    .BIT_MARK     (BM),
    .ZERO_SPACE   (ZS),
    .ONE_SPACE    (OS),
    .GAP          (GP)
  ) dut (
    .i_clk_1us (clk),
    .i_rst_n   (rst_n),
    .bus       (bus)
  );

  typedef struct {
    bit          st;
    bit          rpt;
    logic [31:0] data;
    int          mode;      // 0: release strobe, 1: random input noise mid-frame
    bit          exp_rpt;
    int          exp_len;   // expected start-to-done cycles, 0 = take from the model
  } vec_t;

  int   checks = 0;
  int   errors = 0;
  bit   exp_q[$];
  int   sp_q[$];
  vec_t tbl[8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  function automatic void add_seg(input int n, input bit mark);
    for (int k = 0; k < n; k++) exp_q.push_back(mark && (((k / CH) % 2) == 0));
  endfunction

  function automatic void build(input bit rpt, input logic [31:0] w);
    exp_q.delete();
    add_seg(LM, 1'b1);
    add_seg(rpt ? RS : LS, 1'b0);
    if (!rpt) begin
      for (int i = 0; i < 32; i++) begin
        add_seg(BM, 1'b1);
        add_seg(w[i] ? OS : ZS, 1'b0);
      end
    end
    add_seg(BM, 1'b1);
  endfunction

  // Caller drives the strobe; the first tick here is the edge that starts the frame.
  task automatic run_frame(input string tag, input bit rpt, input logic [31:0] w,
                           input int exp_len, input int mode,
                           input bit nxt_st, input bit nxt_rpt, input logic [31:0] nxt_data);
    int          len;
    int          bad_red;
    int          bad_busy;
    int          bad_done;
    int          first_bad;
    int          run;
    bit          prev;
    bit          er;
    logic [31:0] dec;
    build(rpt, w);
    len = (exp_len > 0) ? exp_len : exp_q.size();
    sp_q.delete();
    bad_red = 0; bad_busy = 0; bad_done = 0; first_bad = -1; run = 0; prev = 1'b0;
    for (int c = 0; c <= len + GP; c++) begin
      tick();
      er = (c < exp_q.size()) ? exp_q[c] : 1'b0;
      if (bus.o_red !== er) begin
        bad_red++;
        if (first_bad < 0) first_bad = c;
      end
      if (bus.o_busy !== (c < len + GP)) bad_busy++;
      if (bus.o_done !== (c == len)) bad_done++;
      if (bus.o_red === 1'b1) begin
        if (!prev && run > 2 * CH) sp_q.push_back(run);
        run  = 0;
        prev = 1'b1;
      end else begin
        run++;
        prev = 1'b0;
      end
      if (c == len + GP) begin
        bus.i_st     = nxt_st;
        bus.i_repeat = nxt_rpt;
        bus.i_data   = nxt_data;
      end else if (mode == 1 && $urandom_range(7) == 0) begin
        bus.i_st     = 1'($urandom);
        bus.i_repeat = 1'($urandom);
        bus.i_data   = $urandom;
      end else if (mode == 2 && c == 5) begin
        bus.i_data = $urandom;
      end else if (mode != 2 && c == 0) begin
        bus.i_st     = 1'b0;
        bus.i_repeat = 1'b0;
      end
    end
    check($sformatf("%s red cycles wrong (first at %0d)", tag, first_bad), bad_red, 0);
    check($sformatf("%s busy cycles wrong", tag), bad_busy, 0);
    check($sformatf("%s done not only at cycle %0d", tag, len), bad_done, 0);
    if (!rpt) begin
      check($sformatf("%s space count", tag), sp_q.size(), 33);
      dec = '0;
      for (int i = 0; i < 32; i++)
        if (i + 1 < sp_q.size()) dec[i] = (sp_q[i + 1] > (ZS + OS) / 2);
      check($sformatf("%s decoded word", tag), dec, w);
    end else begin
      check($sformatf("%s space count", tag), sp_q.size(), 1);
    end
  endtask

  initial begin
    logic [31:0] w;
    int          t10;
    int          done_seen;
    int          busy_seen;

    tbl[0] = '{1'b1, 1'b0, 32'h00FF_A25D, 0, 1'b0, 1353};
    tbl[1] = '{1'b0, 1'b1, 32'h1234_5678, 0, 1'b1, 236};
    tbl[2] = '{1'b1, 1'b1, 32'h0000_0000, 0, 1'b0, 985};
    tbl[3] = '{1'b1, 1'b0, 32'hFFFF_FFFF, 1, 1'b0, 1721};
    for (int i = 4; i < 8; i++) tbl[i] = '{1'b1, 1'b0, $urandom, i % 2, 1'b0, 0};

    bus.i_st     = 1'b1;
    bus.i_repeat = 1'b0;
    bus.i_data   = 32'hDEAD_BEEF;
    repeat (5) tick();
    check("reset red", bus.o_red, 0);
    check("reset busy", bus.o_busy, 0);
    check("reset done", bus.o_done, 0);
    bus.i_st = 1'b0;
    rst_n    = 1'b1;
    repeat (3) tick();
    check("idle busy", bus.o_busy, 0);

    for (int i = 0; i < 8; i++) begin
      bus.i_st     = tbl[i].st;
      bus.i_repeat = tbl[i].rpt;
      bus.i_data   = tbl[i].data;
      run_frame($sformatf("vec%0d", i), tbl[i].exp_rpt, tbl[i].data, tbl[i].exp_len,
                tbl[i].mode, 1'b0, 1'b0, 32'h0);
      tick();
      check($sformatf("vec%0d idle busy", i), bus.o_busy, 0);
    end

    // Strobe held high: second frame must follow the gap with no extra idle cycles.
    w            = $urandom;
    bus.i_st     = 1'b1;
    bus.i_data   = 32'hA5C3_0F96;
    run_frame("held1", 1'b0, 32'hA5C3_0F96, 0, 2, 1'b1, 1'b0, w);
    run_frame("held2", 1'b0, w, 0, 0, 1'b0, 1'b0, 32'h0);
    tick();

    // Reset during bit 10: LED drops at once, no done pulse afterwards.
    w   = $urandom;
    t10 = LM + LS;
    for (int i = 0; i < 10; i++) t10 += BM + (w[i] ? OS : ZS);
    bus.i_st   = 1'b1;
    bus.i_data = w;
    for (int c = 0; c <= t10; c++) begin
      tick();
      bus.i_st = 1'b0;
    end
    check("bit10 mark red", bus.o_red, 1);
    #2 rst_n = 1'b0;
    #1;
    check("async reset red", bus.o_red, 0);
    check("async reset busy", bus.o_busy, 0);
    done_seen = 0;
    busy_seen = 0;
    for (int c = 0; c < 1500; c++) begin
      tick();
      if (c == 5) rst_n = 1'b1;
      if (bus.o_done === 1'b1) done_seen++;
      if (bus.o_busy === 1'b1) busy_seen++;
    end
    check("no done after reset", done_seen, 0);
    check("no busy after reset", busy_seen, 0);
    w            = $urandom;
    bus.i_st     = 1'b1;
    bus.i_data   = w;
    run_frame("after_rst", 1'b0, w, 0, 0, 1'b0, 1'b0, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
